// File: rtl/hwag_coil_channel.sv
// Single ignition-coil channel: drives coil_out between a double-buffered set/reset angle pair.
// Latency: all outputs registered, 1 clk after the qualifying acnt_ena / wr_ena cycle.
// Backpressure: none; writes are accepted or rejected in one cycle, last write before the wrap wins.
module hwag_coil_channel #(
    parameter int ACNT_WIDTH  = 24,
    parameter int DWELL_WIDTH = 24,
    parameter int MAX_ANGLE   = 3839
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   hwag_start,
    input  logic [ACNT_WIDTH-1:0]  acnt,
    input  logic                   acnt_ena,
    input  logic                   wr_ena,
    input  logic [ACNT_WIDTH-1:0]  wr_set,
    input  logic [ACNT_WIDTH-1:0]  wr_reset,
    input  logic [DWELL_WIDTH-1:0] dwell_max,
    input  logic                   fault_clr,
    output logic                   coil_out,
    output logic                   wr_ack,
    output logic                   wr_err,
    output logic                   pending,
    output logic                   fault
);

    typedef enum logic [1:0] {IDLE, ARMED, DWELL, BLOCKED} state_t;

    localparam logic [ACNT_WIDTH-1:0] MAX_A = ACNT_WIDTH'(MAX_ANGLE);

    state_t                 state;
    logic [ACNT_WIDTH-1:0]  shadow_set;
    logic [ACNT_WIDTH-1:0]  shadow_reset;
    logic [ACNT_WIDTH-1:0]  active_set;
    logic [ACNT_WIDTH-1:0]  active_reset;
    logic [ACNT_WIDTH-1:0]  eff_set;
    logic [ACNT_WIDTH-1:0]  eff_reset;
    logic [DWELL_WIDTH-1:0] dwell_cnt;
    logic                   wr_ok;
    logic                   xfer;
    logic                   set_hit;
    logic                   reset_hit;
    logic                   timeout;
    logic                   timeout_evt;

    assign wr_ok = (wr_set <= MAX_A) && (wr_reset <= MAX_A);

    // The pair moves to active while idle, or at the wrap strobe; compares on that
    // same strobe must already see the new pair.
    assign xfer      = pending && ((state == IDLE) || (acnt_ena && (acnt == '0)));
    assign eff_set   = xfer ? shadow_set   : active_set;
    assign eff_reset = xfer ? shadow_reset : active_reset;

    assign set_hit     = acnt_ena && (acnt == eff_set) && (eff_set != eff_reset);
    assign reset_hit   = acnt_ena && (acnt == eff_reset);
    assign timeout     = (dwell_max != '0) && (dwell_cnt == dwell_max - DWELL_WIDTH'(1));
    assign timeout_evt = hwag_start && (state == DWELL) && !reset_hit && timeout;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            shadow_set   <= '0;
            shadow_reset <= '0;
            active_set   <= '0;
            active_reset <= '0;
            pending      <= 1'b0;
            wr_ack       <= 1'b0;
            wr_err       <= 1'b0;
        end else begin
            wr_ack <= wr_ena && wr_ok;
            wr_err <= wr_ena && !wr_ok;
            if (xfer) begin
                active_set   <= shadow_set;
                active_reset <= shadow_reset;
            end
            if (wr_ena && wr_ok) begin
                shadow_set   <= wr_set;
                shadow_reset <= wr_reset;
                pending      <= 1'b1;
            end else if (xfer) begin
                pending      <= 1'b0;
            end
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state     <= IDLE;
            coil_out  <= 1'b0;
            dwell_cnt <= '0;
        end else if (!hwag_start) begin
            state     <= IDLE;
            coil_out  <= 1'b0;
            dwell_cnt <= '0;
        end else begin
            case (state)
                IDLE: begin
                    state <= ARMED;
                end
                ARMED: begin
                    if (set_hit) begin
                        state     <= DWELL;
                        coil_out  <= 1'b1;
                        dwell_cnt <= '0;
                    end
                end
                DWELL: begin
                    // A reset match on the same cycle as the timeout ends the dwell normally.
                    if (reset_hit) begin
                        state    <= ARMED;
                        coil_out <= 1'b0;
                    end else if (timeout) begin
                        state    <= BLOCKED;
                        coil_out <= 1'b0;
                    end else begin
                        dwell_cnt <= dwell_cnt + DWELL_WIDTH'(1);
                    end
                end
                BLOCKED: begin
                    if (reset_hit) begin
                        state <= ARMED;
                    end
                end
                default: begin
                    state    <= IDLE;
                    coil_out <= 1'b0;
                end
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            fault <= 1'b0;
        end else begin
            fault <= (fault && !fault_clr) || timeout_evt;
        end
    end

endmodule

// File: tb/tb_hwag_coil_channel.sv
// Bench for hwag_coil_channel: behavioural model predicts every output cycle,
// a negedge monitor pops predictions and compares them against the DUT.
module tb_hwag_coil_channel;

    localparam int MAXA = 3839;

    typedef struct packed {
        logic coil;
        logic ack;
        logic err;
        logic pend;
        logic flt;
    } exp_t;

    logic        clk;
    logic        rst;
    logic        hwag_start;
    logic [23:0] acnt;
    logic        acnt_ena;
    logic        wr_ena;
    logic [23:0] wr_set;
    logic [23:0] wr_reset;
    logic [23:0] dwell_max;
    logic        fault_clr;
    logic        coil_out;
    logic        wr_ack;
    logic        wr_err;
    logic        pending;
    logic        fault;

    hwag_coil_channel #(.ACNT_WIDTH(24), .DWELL_WIDTH(24), .MAX_ANGLE(MAXA)) dut (
        .clk        (clk),
        .rst        (rst),
        .hwag_start (hwag_start),
        .acnt       (acnt),
        .acnt_ena   (acnt_ena),
        .wr_ena     (wr_ena),
        .wr_set     (wr_set),
        .wr_reset   (wr_reset),
        .dwell_max  (dwell_max),
        .fault_clr  (fault_clr),
        .coil_out   (coil_out),
        .wr_ack     (wr_ack),
        .wr_err     (wr_err),
        .pending    (pending),
        .fault      (fault)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int   n_cmp = 0;
    int   n_err = 0;
    bit   chk_en = 0;
    exp_t exp_q[$];
    exp_t mon_e;
    exp_t mon_a;
    int   run_len = 0;
    int   last_run = 0;

    // Model: angle pairs, whether the channel is locked, charging or blocked,
    // and how many cycles the coil has been high in the current charge.
    int m_sh_s, m_sh_r, m_ac_s, m_ac_r, m_on;
    bit m_pend, m_run, m_chg, m_blk, m_flt;

    task automatic model_reset();
        m_sh_s = 0; m_sh_r = 0; m_ac_s = 0; m_ac_r = 0; m_on = 0;
        m_pend = 0; m_run = 0; m_chg = 0; m_blk = 0; m_flt = 0;
    endtask

    task automatic model_step(output exp_t e);
        bit wrap, ok, hit_s, hit_r, to;
        int s, r;
        wrap = m_pend && (!m_run || (acnt_ena && int'(acnt) == 0));
        s = wrap ? m_sh_s : m_ac_s;
        r = wrap ? m_sh_r : m_ac_r;
        ok = (int'(wr_set) <= MAXA) && (int'(wr_reset) <= MAXA);
        if (wrap) begin
            m_ac_s = m_sh_s; m_ac_r = m_sh_r; m_pend = 0;
        end
        if (wr_ena && ok) begin
            m_sh_s = int'(wr_set); m_sh_r = int'(wr_reset); m_pend = 1;
        end
        hit_s = acnt_ena && int'(acnt) == s;
        hit_r = acnt_ena && int'(acnt) == r;
        to = 0;
        if (!hwag_start) begin
            m_run = 0; m_chg = 0; m_blk = 0; m_on = 0;
        end else if (!m_run) begin
            m_run = 1;
        end else if (m_chg) begin
            if (hit_r) m_chg = 0;
            else if (dwell_max != 0 && m_on + 1 == int'(dwell_max)) begin
                m_chg = 0; m_blk = 1; to = 1;
            end else m_on++;
        end else if (m_blk) begin
            if (hit_r) m_blk = 0;
        end else if (hit_s && s != r) begin
            m_chg = 1; m_on = 0;
        end
        m_flt = (m_flt && !fault_clr) || to;
        e.coil = m_chg;
        e.ack  = wr_ena && ok;
        e.err  = wr_ena && !ok;
        e.pend = m_pend;
        e.flt  = m_flt;
    endtask

    task automatic chk(input string nm, input int act, input int req);
        n_cmp++;
        if (act !== req) begin
            n_err++;
            $display("FAIL %s at %0t: got %0d, want %0d", nm, $time, act, req);
        end
    endtask

    always @(negedge clk) begin
        if (exp_q.size() > 0) begin
            mon_e = exp_q.pop_front();
            mon_a = {coil_out, wr_ack, wr_err, pending, fault};
            n_cmp++;
            if (mon_a !== mon_e) begin
                n_err++;
                $display("FAIL outputs at %0t: coil/ack/err/pend/fault got %b, want %b",
                         $time, mon_a, mon_e);
            end
        end
        if (coil_out === 1'b1) run_len++;
        else if (run_len != 0) begin
            last_run = run_len;
            run_len = 0;
        end
    end

    // Inputs for this cycle are already driven; predict, clock, then queue the prediction.
    task automatic cycle();
        exp_t e;
        model_step(e);
        @(posedge clk);
        #1;
        if (chk_en) exp_q.push_back(e);
        wr_ena = 0;
        fault_clr = 0;
        acnt_ena = 0;
    endtask

    task automatic idle(input int n);
        for (int k = 0; k < n; k++) cycle();
    endtask

    task automatic strobe(input int a, input int gap);
        acnt = 24'(a);
        acnt_ena = 1;
        cycle();
        idle(gap - 1);
    endtask

    task automatic sweep(input int lo, input int hi, input int gap);
        for (int a = lo; a <= hi; a++) strobe(a, gap);
    endtask

    task automatic write(input int s, input int r);
        wr_ena = 1;
        wr_set = 24'(s);
        wr_reset = 24'(r);
        cycle();
    endtask

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1);
    end

    initial begin
        int ang, gap_left, lock_hold;
        rst = 0; hwag_start = 0; acnt = 0; acnt_ena = 0; wr_ena = 0;
        wr_set = 0; wr_reset = 0; dwell_max = 0; fault_clr = 0;
        model_reset();
        #12;
        chk("rst_coil", coil_out, 0);
        chk("rst_ack", wr_ack, 0);
        chk("rst_err", wr_err, 0);
        chk("rst_pending", pending, 0);
        chk("rst_fault", fault, 0);
        @(posedge clk);
        #1;
        rst = 1;
        chk_en = 1;

        // Lock, program 32/96, one full revolution with strobes every 4 clk.
        hwag_start = 1;
        cycle();
        write(32, 96);
        sweep(0, MAXA, 4);
        chk("rev_run_len", last_run, 64 * 4);

        // Max-dwell timeout, then recovery through the reset angle.
        dwell_max = 10;
        write(100, 200);
        sweep(0, 100, 2);
        idle(30);
        chk("timeout_len", last_run, 10);
        chk("timeout_fault", fault, 1);
        strobe(200, 2);
        sweep(0, 100, 2);
        dwell_max = 0;
        sweep(101, 200, 2);
        fault_clr = 1;
        cycle();
        chk("fault_cleared", fault, 0);

        // New pair written mid-dwell waits for the wrap.
        write(32, 96);
        sweep(201, MAXA, 1);
        sweep(0, 49, 2);
        wr_ena = 1; wr_set = 500; wr_reset = 600;
        strobe(50, 2);
        sweep(51, MAXA, 1);
        sweep(0, 700, 1);

        // Out-of-range writes are rejected; a boundary-legal write is accepted.
        write(3840, 10);
        write(10, 3840);
        idle(2);
        write(500, MAXA);
        sweep(701, MAXA, 1);

        // Loss of lock mid-dwell, then relock.
        sweep(0, 549, 1);
        hwag_start = 0;
        idle(3);
        hwag_start = 1;
        sweep(551, MAXA, 1);
        sweep(0, 600, 1);
        sweep(601, MAXA, 1);

        // Equal set/reset disables the channel.
        write(64, 64);
        sweep(0, MAXA, 1);

        // Timer disabled: coil stays high through a long stall.
        write(32, 96);
        sweep(0, 40, 1);
        idle(20000);
        chk("stall_coil", coil_out, 1);
        chk("stall_fault", fault, 0);

        // Asynchronous reset drops the coil without waiting for a clock.
        chk_en = 0;
        exp_q.delete();
        #2;
        rst = 0;
        #1;
        chk("arst_coil", coil_out, 0);
        chk("arst_pending", pending, 0);
        model_reset();
        repeat (2) @(posedge clk);
        #1;
        rst = 1;
        chk_en = 1;

        // Randomized traffic on a 16-angle grid so matches actually occur.
        ang = 0; gap_left = 0; lock_hold = 0;
        dwell_max = 200;
        for (int i = 0; i < 8000; i++) begin
            if ($urandom_range(0, 99) < 3) begin
                wr_ena = 1;
                wr_set = ($urandom_range(0, 19) == 0) ? 24'(3840 + $urandom_range(0, 300))
                                                      : 24'(16 * $urandom_range(0, 239));
                wr_reset = ($urandom_range(0, 19) == 0) ? 24'(3840 + $urandom_range(0, 300))
                                                        : 24'(16 * $urandom_range(0, 239));
            end
            if ($urandom_range(0, 199) == 0) fault_clr = 1;
            if ($urandom_range(0, 399) == 0)
                dwell_max = ($urandom_range(0, 2) == 0) ? 24'(0) : 24'($urandom_range(1, 400));
            if (hwag_start && $urandom_range(0, 999) == 0) begin
                hwag_start = 0;
                lock_hold = $urandom_range(1, 5);
            end else if (!hwag_start) begin
                if (lock_hold == 0) hwag_start = 1;
                else lock_hold--;
            end
            if (gap_left == 0) begin
                ang = (ang + 16 * $urandom_range(1, 2)) % (MAXA + 1);
                acnt = 24'(ang);
                acnt_ena = 1;
                gap_left = ($urandom_range(0, 499) == 0) ? $urandom_range(50, 500)
                                                         : $urandom_range(0, 2);
            end else begin
                gap_left--;
            end
            cycle();
        end

        repeat (2) @(negedge clk);
        chk("queue_drained", exp_q.size(), 0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
